mul_iter_unit: RTL

MUL_ITER_UNIT -- requirements
Module: mul_iter_unit

---
 rtl/mul_iter_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/mul_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_iter_unit
// Description : Iterative 32x32 -> 32 (low half) shift-add multiplier.
//               One partial product is accumulated per clock while in RUN.
//               The low 32 bits of a two's-complement product equal those of
//               the unsigned product, so no sign handling is needed.
//
// Ports       : clk_i    - clock, rising-edge active
//               rst_i    - synchronous active-high reset
//               start_i  - begin a multiply (honoured in IDLE or DONE)
//               kill_i   - flush; aborts any operation, beats start_i
//               data1_i  - multiplicand (32 bit)
//               data2_i  - multiplier   (32 bit)
//               data_o   - low 32 bits of the product, held between results
//               busy_o   - high while the unit is iterating (RUN)
//               done_o   - one-cycle pulse, data_o valid in that cycle
//
// Options     : MUL_EARLY_OUT_EN - when defined, RUN finishes as soon as the
//               remaining multiplier bits are all zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mul_iter_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_data;

    logic [31:0] w_addend;
    logic [31:0] w_acc_next;
    logic [31:0] w_mplier_next;
    logic        w_last;

    // Partial product for this step and the accumulator value it produces.
    // w_acc_next is also what data_o captures on the final step, so the last
    // partial product is never lost.
    assign w_addend      = r_mplier[0] ? r_mcand : 32'd0;
    assign w_acc_next    = r_acc + w_addend;
    assign w_mplier_next = r_mplier >> 1;

`ifdef MUL_EARLY_OUT_EN
    // Once the shifted multiplier is zero no further additions can occur.
    assign w_last = (r_cnt == 5'd31) || (w_mplier_next == 32'd0);
`else
    assign w_last = (r_cnt == 5'd31);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_ST_IDLE;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 32'd0;
            r_cnt    <= 5'd0;
            r_data   <= 32'd0;
        end else if (kill_i) begin
            // Flush: abandon the operation, keep the last published result.
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start_i) begin
                        r_mcand  <= data1_i;
                        r_mplier <= data2_i;
                        r_acc    <= 32'd0;
                        r_cnt    <= 5'd0;
                        r_state  <= c_ST_RUN;
                    end else begin
                        r_state  <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_data  <= w_acc_next;
                        r_state <= c_ST_DONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign data_o = r_data;
    assign busy_o = (r_state == c_ST_RUN);
    assign done_o = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
